// File: rtl/adder_nibble_serial.sv
`default_nettype none
// ============================================================================
// Module   : adder_nibble_serial
// Purpose  : N-bit unsigned adder that reuses one 4-bit carry-lookahead
//            slice over B = N/4 cycles. Nibbles go through LSB first, and a
//            register holds the carry between nibbles. The (N+1)-bit result
//            is built up in place.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - x, y, cin (and sub) valid
//            in_ready   - high in IDLE only
//            x, y       - N-bit operands
//            cin        - carry-in
//            sub        - subtract request (only with ADDER_SERIAL_SUB_EN)
//            out_valid  - high in DONE only
//            out_ready  - consumer accepts sum
//            sum        - N+1 bit result, sum[N] is carry-out / no-borrow
//            busy       - high in RUN or DONE
// Config   : define ADDER_SERIAL_SUB_EN to add the sub port (x - y path)
// Params   : N must be a multiple of 4 and at least 4
// Revision : 1.0 - initial release
// ============================================================================
module adder_nibble_serial #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         busy
);

  localparam int B  = N / 4;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    x_sh;
  logic [N-1:0]    y_sh;
  logic            carry;
  logic [BW-1:0]   beat;

  logic [3:0]      p;
  logic [3:0]      g;
  logic [4:0]      c;
  logic [3:0]      nib;
  logic            accept;

  assign accept = in_valid && (state == IDLE);

  // The outputs come only from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  // The 4-bit lookahead slice works on the low nibble of the shift registers.
  always_comb begin
    p    = x_sh[3:0] ^ y_sh[3:0];
    g    = x_sh[3:0] & y_sh[3:0];
    c    = '0;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib  = p ^ c[3:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = RUN;
      RUN:     if (beat == LAST_BEAT) state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_sh  <= '0;
      y_sh  <= '0;
      carry <= 1'b0;
      beat  <= '0;
      sum   <= '0;
    end else if (accept) begin
      x_sh  <= x;
      beat  <= '0;
      sum   <= '0;
`ifdef ADDER_SERIAL_SUB_EN
      // Subtraction is x + ~y + 1. cin is ignored on this path.
      y_sh  <= sub ? ~y : y;
      carry <= sub ? 1'b1 : cin;
`else
      y_sh  <= y;
      carry <= cin;
`endif
    end else if (state == RUN) begin
      x_sh  <= x_sh >> 4;
      y_sh  <= y_sh >> 4;
      carry <= c[4];
      for (int i = 0; i < B; i++) begin
        if (beat == BW'(i)) begin
          sum[4*i +: 4] <= nib;
        end
      end
      if (beat == LAST_BEAT) begin
        sum[N] <= c[4];
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_nibble_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_nibble_serial
// Purpose  : Self-checking bench for adder_nibble_serial with N = 16.
//            Results expected at accept time are queued and then compared
//            when the result is handed over.
// Config   : define ADDER_SERIAL_SUB_EN to exercise the subtract path
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_nibble_serial;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   sum;
  logic         busy;

  int compared = 0;
  int mismatched = 0;
  logic [N:0] sb_q[$];

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic         sub;
    logic [N:0]   exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  adder_nibble_serial #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
`ifdef ADDER_SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one operation and waits for out_valid. It does not collect.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic sb, input logic [N:0] exp);
    int cyc;
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1;
    tick();
    sb_q.push_back(exp);
    in_valid = 1'b0;
    x = ~a; y = ~b; cin = ~ci; sub = ~sb;  // scramble: must be ignored now
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, 32'd4);
  endtask

  task automatic collect();
    logic [N:0] exp;
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      chk("sum", {15'b0, sum}, {15'b0, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("in_ready_after_done", {31'b0, in_ready}, 32'd1);
    chk("out_valid_after_done", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic sb, input logic [N:0] exp);
    launch(a, b, ci, sb, exp);
    collect();
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_sum",       {15'b0, sum},       32'd0);
    rst_n = 1'b1;
    tick();

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 17'h0BCDF});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000});
`ifdef ADDER_SERIAL_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].exp);
    end

    // Random additions checked against plain wide arithmetic.
    for (int i = 0; i < 6; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc});
    end

    // Backpressure: the result stays held and a stray in_valid is ignored.
    launch(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        x = 16'h0001; y = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
      chk("bp_sum",       {15'b0, sum},       32'h05555);
    end
    collect();
    run_op(16'h2222, 16'h3333, 1'b1, 1'b0, 17'h05556);

    // Reset during beat 2 discards the operation.
    chk("abort_in_ready_before", {31'b0, in_ready}, 32'd1);
    x = 16'h9999; y = 16'h9999; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_busy",      {31'b0, busy},      32'd0);
    chk("abort_sum",       {15'b0, sum},       32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_output", {31'b0, out_valid}, 32'd0);
    end
    run_op(16'h0101, 16'h0202, 1'b0, 1'b0, 17'h00303);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
